// File: rtl/episode_prior.sv
// Episode-history prior: keeps the last HIST_DEPTH episode winners and turns them
// into per-pair additive score biases that fade across gamma cycles.
module episode_prior #(
    parameter int unsigned HIST_DEPTH = 4,
    parameter int unsigned BIAS_W     = 4,
    parameter int unsigned BIAS_MAX   = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gamma_tick,
    input  logic                          theta_tick,
    input  logic [2:0]                    episode_winner,
    input  logic [3:0]                    episode_strength,
    input  logic                          ep_valid,
    input  logic                          ctx_clear,
    output logic [6*BIAS_W-1:0]           bias_vec,
    output logic [2:0]                    prior_pair,
    output logic                          prior_valid,
    output logic [$clog2(HIST_DEPTH):0]   hist_count
);

    localparam int unsigned NPAIR = 6;
    localparam int unsigned CNT_W = $clog2(HIST_DEPTH) + 1;
    localparam int unsigned SUM_W = 7;

    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_PRIMED = 1'b1;

    logic [2:0]       win_q [HIST_DEPTH];
    logic [2:0]       win_d [HIST_DEPTH];
    logic [3:0]       str_q [HIST_DEPTH];
    logic [3:0]       str_d [HIST_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       gcnt_q, gcnt_d;
    logic [0:0]       state_q, state_d;
    logic             theta_d1_q;
    logic             capture_c;

    logic [6*BIAS_W-1:0] bias_vec_q, bias_vec_d;
    logic [2:0]          prior_pair_q, prior_pair_d;
    logic                prior_valid_q, prior_valid_d;

    logic [SUM_W-1:0]  raw_c;
    logic [BIAS_W-1:0] sat_c;
    logic [BIAS_W-1:0] bias_c [NPAIR];
    logic [BIAS_W-1:0] best_c;
    logic [1:0]        shift_c;

    assign capture_c = theta_d1_q & ep_valid;

    // History, gamma counter and FSM next state; ctx_clear outranks capture.
    always_comb begin
        win_d   = win_q;
        str_d   = str_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        state_d = state_q;

        if (ctx_clear) begin
            for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
                win_d[k] = 3'd0;
                str_d[k] = 4'd0;
            end
            cnt_d  = '0;
            gcnt_d = 3'd0;
        end else if (capture_c) begin
            for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
                win_d[k] = win_q[k-1];
                str_d[k] = str_q[k-1];
            end
            win_d[0] = episode_winner;
            str_d[0] = episode_strength;
            if (cnt_q != CNT_W'(HIST_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            gcnt_d = 3'd0;
        end else if (gamma_tick && (gcnt_q != 3'd7)) begin
            gcnt_d = gcnt_q + 3'd1;
        end

        case (state_q)
            S_EMPTY:  if (capture_c && !ctx_clear) state_d = S_PRIMED;
            S_PRIMED: if (ctx_clear)               state_d = S_EMPTY;
            default:                               state_d = S_EMPTY;
        endcase
    end

    // Bias per pair from the current history; gcnt>>1 never exceeds 3 for a 3-bit count.
    always_comb begin
        shift_c    = 2'(gcnt_q >> 1);
        raw_c      = '0;
        sat_c      = '0;
        bias_vec_d = '0;
        for (int unsigned p = 0; p < NPAIR; p++) begin
            raw_c = '0;
            for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
                if ((CNT_W'(k) < cnt_q) && (win_q[k] == 3'(p))) begin
                    raw_c = raw_c + SUM_W'(str_q[k] >> k);
                end
            end
            sat_c     = (raw_c > SUM_W'(BIAS_MAX)) ? BIAS_W'(BIAS_MAX) : BIAS_W'(raw_c);
            bias_c[p] = (state_q == S_PRIMED) ? (sat_c >> shift_c) : '0;
            bias_vec_d[p*BIAS_W +: BIAS_W] = bias_c[p];
        end

        best_c       = bias_c[0];
        prior_pair_d = 3'd0;
        for (int unsigned p = 1; p < NPAIR; p++) begin
            if (bias_c[p] > best_c) begin
                best_c       = bias_c[p];
                prior_pair_d = 3'(p);
            end
        end
        prior_valid_d = (state_q == S_PRIMED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
                win_q[k] <= 3'd0;
                str_q[k] <= 4'd0;
            end
            cnt_q         <= '0;
            gcnt_q        <= 3'd0;
            state_q       <= S_EMPTY;
            theta_d1_q    <= 1'b0;
            bias_vec_q    <= '0;
            prior_pair_q  <= 3'd0;
            prior_valid_q <= 1'b0;
        end else begin
            win_q         <= win_d;
            str_q         <= str_d;
            cnt_q         <= cnt_d;
            gcnt_q        <= gcnt_d;
            state_q       <= state_d;
            theta_d1_q    <= theta_tick;
            bias_vec_q    <= bias_vec_d;
            prior_pair_q  <= prior_pair_d;
            prior_valid_q <= prior_valid_d;
        end
    end

    assign bias_vec    = bias_vec_q;
    assign prior_pair  = prior_pair_q;
    assign prior_valid = prior_valid_q;
    assign hist_count  = cnt_q;

endmodule

// File: tb/tb_episode_prior.sv
// Self-checking bench for episode_prior: queue-based reference model compared every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_episode_prior;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gamma_tick, theta_tick, ep_valid, ctx_clear;
    logic [2:0]  episode_winner;
    logic [3:0]  episode_strength;
    logic [23:0] bias_vec;
    logic [2:0]  prior_pair;
    logic        prior_valid;
    logic [2:0]  hist_count;

    int checks   = 0;
    int failures = 0;

    episode_prior #(.HIST_DEPTH(4), .BIAS_W(4), .BIAS_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .gamma_tick(gamma_tick), .theta_tick(theta_tick),
        .episode_winner(episode_winner), .episode_strength(episode_strength),
        .ep_valid(ep_valid), .ctx_clear(ctx_clear), .bias_vec(bias_vec),
        .prior_pair(prior_pair), .prior_valid(prior_valid), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    // Reference model: newest entry at queue front.
    int mw[$];
    int ms[$];
    int mg;
    bit mprimed;
    bit mth;
    logic [23:0] e_bias;
    int e_pair;
    bit e_valid;
    int e_cnt;

    function automatic logic [23:0] model_bias();
        int raw [6];
        int b;
        logic [23:0] v;
        v = '0;
        for (int p = 0; p < 6; p++) raw[p] = 0;
        for (int k = 0; k < mw.size(); k++)
            if (mw[k] < 6) raw[mw[k]] += ms[k] / (1 << k);
        for (int p = 0; p < 6; p++) begin
            b = (raw[p] > 15) ? 15 : raw[p];
            b = b / (1 << ((mg / 2 > 3) ? 3 : mg / 2));
            v[p*4 +: 4] = mprimed ? 4'(b) : 4'd0;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw.delete(); ms.delete();
            mg = 0; mprimed = 0; mth = 0;
            e_bias = '0; e_pair = 0; e_valid = 0; e_cnt = 0;
        end else begin
            int best;
            e_bias  = model_bias();
            e_valid = mprimed;
            e_pair  = 0; best = -1;
            for (int p = 0; p < 6; p++)
                if (int'(e_bias[p*4 +: 4]) > best) begin best = int'(e_bias[p*4 +: 4]); e_pair = p; end
            if (ctx_clear) begin
                mw.delete(); ms.delete(); mg = 0; mprimed = 0;
            end else if (mth && ep_valid) begin
                mw.push_front(int'(episode_winner));
                ms.push_front(int'(episode_strength));
                if (mw.size() > 4) begin void'(mw.pop_back()); void'(ms.pop_back()); end
                mg = 0; mprimed = 1;
            end else if (gamma_tick && mg < 7) begin
                mg++;
            end
            mth   = theta_tick;
            e_cnt = mw.size();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_bias_vec", 32'(bias_vec), 32'(e_bias));
            check("model_prior_pair", 32'(prior_pair), 32'(e_pair));
            check("model_prior_valid", 32'(prior_valid), 32'(e_valid));
            check("model_hist_count", 32'(hist_count), 32'(e_cnt));
        end
    end

    function automatic int fld(input int p);
        logic [23:0] v;
        v = bias_vec;
        return int'(v[p*4 +: 4]);
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Ends two edges after the capture edge, i.e. once the capture is visible.
    task automatic capture(input int w, input int s, input bit clr);
        theta_tick = 1'b1; ep_valid = 1'b1;
        episode_winner = 3'(w); episode_strength = 4'(s);
        @(negedge clk);
        theta_tick = 1'b0; ctx_clear = clr;
        @(negedge clk);
        ep_valid = 1'b0; ctx_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic gammas(input int n);
        for (int i = 0; i < n; i++) begin
            gamma_tick = 1'b1; @(negedge clk);
            gamma_tick = 1'b0; @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; gamma_tick = 0; theta_tick = 0; ep_valid = 0; ctx_clear = 0;
        episode_winner = 0; episode_strength = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lit("reset_bias", int'(bias_vec), 0);
        lit("reset_valid", int'(prior_valid), 0);

        // theta pulses without ep_valid must not capture
        for (int i = 0; i < 2; i++) begin
            theta_tick = 1; episode_winner = 3; episode_strength = 9;
            @(negedge clk); theta_tick = 0; gamma_tick = 1;
            @(negedge clk); gamma_tick = 0;
            @(negedge clk);
        end
        lit("idle_bias", int'(bias_vec), 0);
        lit("idle_count", int'(hist_count), 0);
        lit("idle_pair", int'(prior_pair), 0);
        lit("idle_valid", int'(prior_valid), 0);

        capture(2, 6, 0);
        lit("one_bias2", fld(2), 6);
        lit("one_bias_vec", int'(bias_vec), 6 << 8);
        lit("one_pair", int'(prior_pair), 2);
        lit("one_valid", int'(prior_valid), 1);
        lit("one_count", int'(hist_count), 1);

        capture(1, 8, 0); capture(1, 8, 0); capture(3, 8, 0); capture(1, 8, 0);
        lit("four_bias1", fld(1), 11);
        lit("four_bias3", fld(3), 4);
        lit("four_bias2", fld(2), 0);
        lit("four_pair", int'(prior_pair), 1);
        lit("four_count", int'(hist_count), 4);

        capture(5, 8, 0);
        lit("fifth_bias5", fld(5), 8);
        lit("fifth_bias1", fld(1), 5);
        lit("fifth_bias3", fld(3), 2);
        lit("fifth_pair", int'(prior_pair), 5);
        lit("fifth_count", int'(hist_count), 4);

        for (int i = 0; i < 4; i++) capture(0, 15, 0);
        lit("sat_bias0", fld(0), 15);
        gammas(2); lit("decay2_bias0", fld(0), 7);
        gammas(2); lit("decay4_bias0", fld(0), 3);
        gammas(2); lit("decay6_bias0", fld(0), 1);
        gammas(2); lit("decay8_bias0", fld(0), 1);

        // capture coinciding with gamma_tick: capture resets the decay
        gamma_tick = 1; capture(0, 15, 0); gamma_tick = 0;
        @(negedge clk);
        lit("cap_gamma_bias0", fld(0), 15);

        capture(4, 9, 1);
        lit("clr_bias", int'(bias_vec), 0);
        lit("clr_count", int'(hist_count), 0);
        lit("clr_valid", int'(prior_valid), 0);

        capture(0, 8, 0); capture(4, 4, 0);
        lit("tie_bias0", fld(0), 4);
        lit("tie_bias4", fld(4), 4);
        lit("tie_pair", int'(prior_pair), 0);

        // asynchronous reset away from the clock edge
        #2 rst_n = 1'b0;
        #1;
        lit("async_rst_valid", int'(prior_valid), 0);
        lit("async_rst_bias", int'(bias_vec), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        lit("post_rst_count", int'(hist_count), 0);
        capture(3, 5, 0);
        lit("post_rst_bias3", fld(3), 5);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
